// File: rtl/hdc_rule90_hv_stream.sv
// Rule-90 cellular-automaton hypervector generator: expands one seed HV into a
// stream of NUM_HV item-memory HVs over a valid/ready interface.
module hdc_rule90_hv_stream #(
  parameter int HV_DIMENSION = 2000,
  parameter int NUM_HV       = 23,
  parameter int STEPS_PER_HV = 1,
  parameter int BOUNDARY     = 0,
  parameter int IDX_WIDTH    = (NUM_HV > 1) ? $clog2(NUM_HV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HV_DIMENSION-1:0] seed_hv,
  input  logic                    seed_hv_valid,
  output logic                    seed_hv_ready,
  input  logic                    restart,
  output logic [HV_DIMENSION-1:0] hv_out,
  output logic [IDX_WIDTH-1:0]    hv_idx,
  output logic                    hv_valid,
  input  logic                    hv_ready,
  output logic                    hv_last,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [HV_DIMENSION-1:0] r_seed;
  logic [HV_DIMENSION-1:0] r_work;
  logic [HV_DIMENSION-1:0] w_advanced;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic                    w_seedFire;
  logic                    w_isLast;

  // Neighbour indices are taken modulo D so no select ever leaves the vector;
  // null mode then forces the two wrapped reads at the edges to zero.
  function automatic logic [HV_DIMENSION-1:0] rule90Step(input logic [HV_DIMENSION-1:0] cur);
    logic [HV_DIMENSION-1:0] nxt;
    logic                    leftBit;
    logic                    rightBit;
    int                      li;
    int                      ri;
    nxt = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      li       = (i + HV_DIMENSION - 1) % HV_DIMENSION;
      ri       = (i + 1) % HV_DIMENSION;
      leftBit  = cur[li];
      rightBit = cur[ri];
      if (BOUNDARY != 0 && i == 0) leftBit = 1'b0;
      if (BOUNDARY != 0 && i == HV_DIMENSION - 1) rightBit = 1'b0;
      nxt[i] = leftBit ^ rightBit;
    end
    return nxt;
  endfunction

  always_comb begin
    w_advanced = r_work;
    for (int s = 0; s < STEPS_PER_HV; s++) begin
      w_advanced = rule90Step(w_advanced);
    end
  end

  assign w_seedFire = seed_hv_valid && (r_state == IDLE || r_state == DONE);
  assign w_isLast   = (r_idx == IDX_WIDTH'(NUM_HV - 1));
  assign hv_out     = r_work;
  assign hv_idx     = r_idx;

  always_comb begin
    w_nextState   = r_state;
    hv_valid      = 1'b0;
    busy          = 1'b0;
    seed_hv_ready = 1'b1;
    hv_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_seedFire) w_nextState = EMIT;
      end
      EMIT: begin
        hv_valid      = 1'b1;
        busy          = 1'b1;
        seed_hv_ready = 1'b0;
        hv_last       = w_isLast;
        if (!restart && hv_ready && w_isLast) w_nextState = DONE;
      end
      DONE: begin
        if (w_seedFire || restart) w_nextState = EMIT;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_seed  <= '0;
      r_work  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_seedFire) begin
            r_seed <= seed_hv;
            r_work <= seed_hv;
            r_idx  <= '0;
          end
        end
        EMIT: begin
          // A restart discards whatever handshake happens in the same cycle.
          if (restart) begin
            r_work <= r_seed;
            r_idx  <= '0;
          end else if (hv_ready && !w_isLast) begin
            r_work <= w_advanced;
            r_idx  <= r_idx + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          if (w_seedFire) begin
            r_seed <= seed_hv;
            r_work <= seed_hv;
            r_idx  <= '0;
          end else if (restart) begin
            r_work <= r_seed;
            r_idx  <= '0;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_rule90_hv_stream.sv
// Scoreboard bench for hdc_rule90_hv_stream: three small D=8 variants run in
// lockstep plus one default-parameter instance for stalls and mid-stream reset.
module tb_hdc_rule90_hv_stream;

  localparam int BD = 2000;
  localparam int BN = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       sRst, sSeedValid, sRestart, sReady;
  logic [7:0] sSeed;
  logic       aSeedReady, aValid, aLast, aBusy;
  logic       bSeedReady, bValid, bLast, bBusy;
  logic       cSeedReady, cValid, cLast, cBusy;
  logic [7:0] aOut, bOut, cOut;
  logic [1:0] aIdx, bIdx, cIdx;

  logic          gRst, gSeedValid, gRestart, gReady;
  logic [BD-1:0] gSeed, gOut;
  logic          gSeedReady, gValid, gLast, gBusy;
  logic [4:0]    gIdx;

  hdc_rule90_hv_stream #(.HV_DIMENSION(8), .NUM_HV(3), .STEPS_PER_HV(1), .BOUNDARY(0)) uA (
    .clk(clk), .rst(sRst), .seed_hv(sSeed), .seed_hv_valid(sSeedValid), .seed_hv_ready(aSeedReady),
    .restart(sRestart), .hv_out(aOut), .hv_idx(aIdx), .hv_valid(aValid), .hv_ready(sReady),
    .hv_last(aLast), .busy(aBusy));

  hdc_rule90_hv_stream #(.HV_DIMENSION(8), .NUM_HV(3), .STEPS_PER_HV(1), .BOUNDARY(1)) uB (
    .clk(clk), .rst(sRst), .seed_hv(sSeed), .seed_hv_valid(sSeedValid), .seed_hv_ready(bSeedReady),
    .restart(sRestart), .hv_out(bOut), .hv_idx(bIdx), .hv_valid(bValid), .hv_ready(sReady),
    .hv_last(bLast), .busy(bBusy));

  hdc_rule90_hv_stream #(.HV_DIMENSION(8), .NUM_HV(3), .STEPS_PER_HV(2), .BOUNDARY(0)) uC (
    .clk(clk), .rst(sRst), .seed_hv(sSeed), .seed_hv_valid(sSeedValid), .seed_hv_ready(cSeedReady),
    .restart(sRestart), .hv_out(cOut), .hv_idx(cIdx), .hv_valid(cValid), .hv_ready(sReady),
    .hv_last(cLast), .busy(cBusy));

  hdc_rule90_hv_stream uG (
    .clk(clk), .rst(gRst), .seed_hv(gSeed), .seed_hv_valid(gSeedValid), .seed_hv_ready(gSeedReady),
    .restart(gRestart), .hv_out(gOut), .hv_idx(gIdx), .hv_valid(gValid), .hv_ready(gReady),
    .hv_last(gLast), .busy(gBusy));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [1:0] idx;
    logic       last;
  } smallExp_t;

  typedef struct {
    logic [BD-1:0] hv;
    logic [4:0]    idx;
    logic          last;
  } bigExp_t;

  smallExp_t sQ[$];
  bigExp_t   gQ[$];

  // Rule-90 reference built from whole-vector rotates/shifts.
  function automatic logic [7:0] cyc8(input logic [7:0] v);
    return {v[0], v[7:1]} ^ {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] nul8(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ {v[6:0], 1'b0};
  endfunction

  function automatic logic [BD-1:0] cycBig(input logic [BD-1:0] v);
    return {v[0], v[BD-1:1]} ^ {v[BD-2:0], v[BD-1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkWide(input string tag, input logic [BD-1:0] got, input logic [BD-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed low64 %0h expected low64 %0h (%0d bits differ)",
             tag, got[63:0], exp[63:0], $countones(got ^ exp));
    end
  endtask

  task automatic pushSmall(input logic [7:0] seed);
    smallExp_t e;
    logic [7:0] a, b, c;
    a = seed; b = seed; c = seed;
    for (int k = 0; k < 3; k++) begin
      e.a = a; e.b = b; e.c = c; e.idx = 2'(k); e.last = (k == 2);
      sQ.push_back(e);
      a = cyc8(a); b = nul8(b); c = cyc8(cyc8(c));
    end
  endtask

  task automatic pushBig(input logic [BD-1:0] seed);
    bigExp_t e;
    logic [BD-1:0] v;
    v = seed;
    for (int k = 0; k < BN; k++) begin
      e.hv = v; e.idx = 5'(k); e.last = (k == BN - 1);
      gQ.push_back(e);
      v = cycBig(v);
    end
  endtask

  // Called at a falling edge: compares the current outputs, then lets one cycle pass.
  task automatic stepSmall(input logic ready);
    sReady = ready;
    if (sQ.size() > 0) begin
      check("aValid", 64'(aValid), 64'(1)); check("bValid", 64'(bValid), 64'(1)); check("cValid", 64'(cValid), 64'(1));
      check("aOut", 64'(aOut), 64'(sQ[0].a)); check("bOut", 64'(bOut), 64'(sQ[0].b)); check("cOut", 64'(cOut), 64'(sQ[0].c));
      check("aIdx", 64'(aIdx), 64'(sQ[0].idx)); check("bIdx", 64'(bIdx), 64'(sQ[0].idx)); check("cIdx", 64'(cIdx), 64'(sQ[0].idx));
      check("aLast", 64'(aLast), 64'(sQ[0].last)); check("bLast", 64'(bLast), 64'(sQ[0].last)); check("cLast", 64'(cLast), 64'(sQ[0].last));
      check("aBusy", 64'(aBusy), 64'(1)); check("bBusy", 64'(bBusy), 64'(1)); check("cBusy", 64'(cBusy), 64'(1));
      check("aSeedReady", 64'(aSeedReady), 64'(0)); check("bSeedReady", 64'(bSeedReady), 64'(0)); check("cSeedReady", 64'(cSeedReady), 64'(0));
      if (ready) void'(sQ.pop_front());
    end else begin
      check("aValidIdle", 64'(aValid), 64'(0)); check("bValidIdle", 64'(bValid), 64'(0)); check("cValidIdle", 64'(cValid), 64'(0));
      check("aLastIdle", 64'(aLast), 64'(0)); check("aBusyIdle", 64'(aBusy), 64'(0));
      check("bBusyIdle", 64'(bBusy), 64'(0)); check("cBusyIdle", 64'(cBusy), 64'(0));
      check("aSeedReadyIdle", 64'(aSeedReady), 64'(1)); check("bSeedReadyIdle", 64'(bSeedReady), 64'(1));
      check("cSeedReadyIdle", 64'(cSeedReady), 64'(1));
    end
    @(negedge clk);
  endtask

  task automatic loadSmall(input logic [7:0] seed);
    sSeed = seed;
    sSeedValid = 1'b1;
    check("aSeedReadyLoad", 64'(aSeedReady), 64'(1));
    @(negedge clk);
    sSeedValid = 1'b0;
    sRestart = 1'b0;
    sQ.delete();
    pushSmall(seed);
  endtask

  task automatic stepBig(input logic ready);
    gReady = ready;
    if (gQ.size() > 0) begin
      check("gValid", 64'(gValid), 64'(1));
      checkWide("gOut", gOut, gQ[0].hv);
      check("gIdx", 64'(gIdx), 64'(gQ[0].idx));
      check("gLast", 64'(gLast), 64'(gQ[0].last));
      check("gBusy", 64'(gBusy), 64'(1));
      check("gSeedReady", 64'(gSeedReady), 64'(0));
      if (ready) void'(gQ.pop_front());
    end else begin
      check("gValidDone", 64'(gValid), 64'(0));
      check("gBusyDone", 64'(gBusy), 64'(0));
      check("gSeedReadyDone", 64'(gSeedReady), 64'(1));
    end
    @(negedge clk);
  endtask

  task automatic loadBig(input logic [BD-1:0] seed);
    gSeed = seed;
    gSeedValid = 1'b1;
    @(negedge clk);
    gSeedValid = 1'b0;
    gQ.delete();
    pushBig(seed);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BD-1:0] seedA;
    logic [BD-1:0] seedB;
    int budget;

    sRst = 1'b0; sSeed = '0; sSeedValid = 1'b0; sRestart = 1'b0; sReady = 1'b0;
    gRst = 1'b0; gSeed = '0; gSeedValid = 1'b0; gRestart = 1'b0; gReady = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    check("rstOut", 64'(aOut), 64'(0)); check("rstIdx", 64'(aIdx), 64'(0));
    check("rstValid", 64'(aValid), 64'(0)); check("rstLast", 64'(aLast), 64'(0));
    check("rstBusy", 64'(aBusy), 64'(0)); check("rstSeedReady", 64'(aSeedReady), 64'(1));
    checkWide("rstBigOut", gOut, '0);
    sRst = 1'b1;
    gRst = 1'b1;
    @(negedge clk);

    $display("[TB] restart ignored in IDLE");
    sRestart = 1'b1;
    stepSmall(1'b1);
    sRestart = 1'b0;
    stepSmall(1'b1);

    $display("[TB] basic stream, seed 00000001");
    loadSmall(8'h01);
    repeat (4) stepSmall(1'b1);
    check("doneHoldsLast", 64'(aOut), 64'(8'b01000100));

    $display("[TB] restart in DONE, then stall at idx1 with seed offered");
    sRestart = 1'b1;
    stepSmall(1'b1);
    sRestart = 1'b0;
    sQ.delete();
    pushSmall(8'h01);
    stepSmall(1'b1);
    sSeed = 8'hA5;
    sSeedValid = 1'b1;
    repeat (5) stepSmall(1'b0);
    sSeedValid = 1'b0;
    stepSmall(1'b1);

    $display("[TB] restart in EMIT at idx2 beats the handshake");
    sRestart = 1'b1;
    stepSmall(1'b1);
    sRestart = 1'b0;
    sQ.delete();
    pushSmall(8'h01);
    repeat (4) stepSmall(1'b1);

    $display("[TB] seed and restart together in DONE");
    sRestart = 1'b1;
    loadSmall(8'h3C);
    repeat (4) stepSmall(1'b1);

    $display("[TB] default parameters, random stalls, reset at idx10");
    for (int i = 0; i < BD; i++) seedA[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < BD; i++) seedB[i] = 1'($urandom_range(0, 1));
    loadBig(seedA);
    budget = 0;
    while (budget < 400 && gQ.size() > 0 && gQ[0].idx != 5'd10) begin
      stepBig(1'($urandom_range(0, 1)));
      budget++;
    end
    check("bigIdxBeforeReset", 64'(gIdx), 64'(10));
    check("bigValidBeforeReset", 64'(gValid), 64'(1));
    gRst = 1'b0;
    #1;
    checkWide("midRstOut", gOut, '0);
    check("midRstValid", 64'(gValid), 64'(0));
    check("midRstIdx", 64'(gIdx), 64'(0));
    check("midRstLast", 64'(gLast), 64'(0));
    check("midRstBusy", 64'(gBusy), 64'(0));
    check("midRstSeedReady", 64'(gSeedReady), 64'(1));
    gQ.delete();
    @(negedge clk);
    gRst = 1'b1;
    gRestart = 1'b1;
    @(negedge clk);
    gRestart = 1'b0;
    check("seedLostAfterRst", 64'(gValid), 64'(0));
    loadBig(seedB);
    for (int k = 0; k < BN + 1; k++) stepBig(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
